// File: rtl/led_rgb_pkg.sv
// Shared definitions for the LED RGB AXI4-Lite register block and the
// fabric-side master that drives it.
//   state_t        : master FSM states
//   RESP_*         : AXI BRESP/RRESP encodings
//   LED_REG_*      : byte offsets of the LED RGB slave registers
package led_rgb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // All writes are full-word.
    localparam logic [3:0] WSTRB_ALL = 4'hF;

    // LED RGB slave register map (byte offsets).
    localparam logic [4:0] LED_REG_DURATION = 5'h00;
    localparam logic [4:0] LED_REG_RED      = 5'h04;
    localparam logic [4:0] LED_REG_GREEN    = 5'h08;
    localparam logic [4:0] LED_REG_BLUE     = 5'h0C;
    localparam logic [4:0] LED_REG_STATUS   = 5'h10;

endpackage

// File: rtl/axil_led_rgb_master.sv
// Single-outstanding AXI4-Lite initiator. A cmd valid/ready request becomes
// exactly one AXI-Lite write (AW+W then B) or read (AR then R); the result is
// returned on a rsp valid/ready channel that is held until consumed.
// Ports:
//   aclk, aresetn                 clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata   request channel
//   rsp_valid/ready/rdata/resp         response channel (rdata 0 for writes)
//   aw*, w*, b*, ar*, r*               AXI4-Lite master interface
module axil_led_rgb_master
    import led_rgb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    state_t state, state_nxt;
    logic   cmd_accept;

    assign cmd_ready  = (state == ST_IDLE);
    assign bready     = (state == ST_WR_B);
    assign rready     = (state == ST_RD_R);
    assign rsp_valid  = (state == ST_RSP);
    assign wstrb      = WSTRB_ALL;
    assign cmd_accept = cmd_valid && cmd_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cmd_valid) state_nxt = cmd_write ? ST_WR_AW_W : ST_RD_AR;
            // A channel counts as done once its valid has dropped or is
            // handshaking this cycle; leave only when both are done.
            ST_WR_AW_W: if ((!awvalid || awready) && (!wvalid || wready))
                            state_nxt = ST_WR_B;
            ST_WR_B:    if (bvalid)    state_nxt = ST_RSP;
            ST_RD_AR:   if (arready)   state_nxt = ST_RD_R;
            ST_RD_R:    if (rvalid)    state_nxt = ST_RSP;
            ST_RSP:     if (rsp_ready) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awaddr    <= '0;
            wdata     <= '0;
            araddr    <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            if (cmd_accept) begin
                if (cmd_write) begin
                    awaddr  <= cmd_addr;
                    wdata   <= cmd_wdata;
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                end else begin
                    araddr  <= cmd_addr;
                    arvalid <= 1'b1;
                end
            end
            // AW and W retire independently; once low they stay low.
            if (state == ST_WR_AW_W) begin
                if (awready) awvalid <= 1'b0;
                if (wready)  wvalid  <= 1'b0;
            end
            if (state == ST_RD_AR && arready) arvalid <= 1'b0;
            if (state == ST_WR_B && bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= bresp;
            end
            if (state == ST_RD_R && rvalid) begin
                rsp_rdata <= rdata;
                rsp_resp  <= rresp;
            end
        end
    end

endmodule
